// File: rtl/ucsbece154b_fetch_queue.sv
// Decoupling fetch queue between instruction memory and Decode.
// Fetch runs ahead of Decode until the queue is full; a redirect flushes the queue and restarts fetch.
module ucsbece154b_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] PC_START  = 32'h0001_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic                     imem_ack_i,
  input  logic [31:0]              imem_rdata_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  input  logic                     stall_i,
  output logic                     valid_d_o,
  output logic [31:0]              InstrD_o,
  output logic [31:0]              PCD_o,
  output logic [31:0]              PCPlus4D_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  logic [31:0]     pcf_q, pcf_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [31:0]     pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic            push, pop;
  logic            unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  always_comb begin
    // Request is held low during reset so nothing can be accepted before release.
    imem_req_o = reset && (count_q != Full) && !redirect_i;
    push       = imem_req_o && imem_ack_i;
    pop        = (count_q != '0) && !stall_i;

    pcf_d    = pcf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (redirect_i) begin
      pcf_d    = {redirect_pc_i[31:2], 2'b00};
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        pcf_d    = pcf_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcf_q    <= PC_START;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pcf_q    <= pcf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: head outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= pcf_q;
      instr_mem[wr_ptr_q] <= imem_rdata_i;
    end
  end

  always_comb begin
    imem_addr_o = pcf_q;
    count_o     = count_q;
    valid_d_o   = (count_q != '0);
    InstrD_o    = valid_d_o ? instr_mem[rd_ptr_q] : NOP_INSTR;
    PCD_o       = valid_d_o ? pc_mem[rd_ptr_q] : 32'd0;
    PCPlus4D_o  = valid_d_o ? (pc_mem[rd_ptr_q] + 32'd4) : 32'd0;
  end

endmodule

// File: tb/tb_ucsbece154b_fetch_queue.sv
// Bench for the fetch queue: directed scenarios plus a randomized run against a queue-based model.
module tb_ucsbece154b_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] PC_START = 32'h0001_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        stall_i = 1'b0;
  logic        valid_d_o;
  logic [31:0] InstrD_o, PCD_o, PCPlus4D_o;
  logic [2:0]  count_o;

  int total = 0;
  int bad = 0;

  // Reference model: a plain FIFO of fetched {pc, instr} pairs and the fetch PC.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_instr[$];
  logic [31:0] m_pcf;

  ucsbece154b_fetch_queue #(
    .DEPTH(DEPTH), .PC_START(PC_START), .NOP_INSTR(NOP)
  ) dut (
    .clk(clk), .reset(reset),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .stall_i(stall_i),
    .valid_d_o(valid_d_o), .InstrD_o(InstrD_o), .PCD_o(PCD_o),
    .PCPlus4D_o(PCPlus4D_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq_pc.delete();
    mq_instr.delete();
    m_pcf = PC_START;
  endtask

  // Applies one cycle of inputs, advances the model across the edge, returns at the next negedge.
  task automatic drive_cycle(input logic red, input logic [31:0] rpc, input logic ack,
                             input logic [31:0] rdata, input logic stall);
    logic m_req;
    redirect_i    = red;
    redirect_pc_i = rpc;
    imem_ack_i    = ack;
    imem_rdata_i  = rdata;
    stall_i       = stall;
    m_req = (mq_pc.size() < DEPTH) && !red;
    if (red) begin
      mq_pc.delete();
      mq_instr.delete();
      m_pcf = {rpc[31:2], 2'b00};
    end else begin
      if (mq_pc.size() > 0 && !stall) begin
        void'(mq_pc.pop_front());
        void'(mq_instr.pop_front());
      end
      if (m_req && ack) begin
        mq_pc.push_back(m_pcf);
        mq_instr.push_back(rdata);
        m_pcf = m_pcf + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    imem_ack_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    redirect_i = 1'b0;
    imem_ack_i = 1'b0;
    stall_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    imem_ack_i = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (valid_d_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_d_o); end
    total++; if (InstrD_o !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", InstrD_o, NOP); end
    total++; if (PCD_o !== 32'd0 || PCPlus4D_o !== 32'd0) begin bad++;
      $display("FAIL reset_pcd got=%h/%h exp=0/0", PCD_o, PCPlus4D_o); end
    total++; if (imem_addr_o !== PC_START) begin bad++; $display("FAIL reset_addr got=%h exp=%h", imem_addr_o, PC_START); end
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", imem_req_o); end
    imem_ack_i = 1'b0;
    reset = 1'b1;
    #1;
    total++; if (imem_req_o !== 1'b1) begin bad++; $display("FAIL release_req got=%b exp=1", imem_req_o); end
  endtask

  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive_cycle(1'b0, 32'd0, 1'b1, $urandom, 1'b0);
      total++; if (valid_d_o !== 1'b1 || PCD_o !== PC_START + 32'(4 * k)) begin bad++;
        $display("FAIL stream_pcd k=%0d got=%b/%h exp=1/%h", k, valid_d_o, PCD_o, PC_START + 32'(4 * k)); end
      total++; if (PCPlus4D_o !== PC_START + 32'(4 * k + 4) || InstrD_o !== mq_instr[0]) begin bad++;
        $display("FAIL stream_head k=%0d got=%h/%h exp=%h/%h", k, PCPlus4D_o, InstrD_o,
                 PC_START + 32'(4 * k + 4), mq_instr[0]); end
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    repeat (4) drive_cycle(1'b0, 32'd0, 1'b1, $urandom, 1'b1);
    total++; if (count_o !== 3'd4 || imem_req_o !== 1'b0 || imem_addr_o !== 32'h0001_0010) begin bad++;
      $display("FAIL full_state got=%0d/%b/%h exp=4/0/00010010", count_o, imem_req_o, imem_addr_o); end
    drive_cycle(1'b0, 32'd0, 1'b1, $urandom, 1'b1);
    total++; if (count_o !== 3'd4) begin bad++; $display("FAIL full_ignore_ack got=%0d exp=4", count_o); end
    // Pop while full with ack high: must not push in the same cycle.
    total++; if (PCD_o !== 32'h0001_0000) begin bad++; $display("FAIL drain0 got=%h exp=00010000", PCD_o); end
    drive_cycle(1'b0, 32'd0, 1'b1, $urandom, 1'b0);
    total++; if (count_o !== 3'd3 || imem_addr_o !== 32'h0001_0010) begin bad++;
      $display("FAIL full_pop_no_push got=%0d/%h exp=3/00010010", count_o, imem_addr_o); end
    for (int i = 1; i < 4; i++) begin
      total++; if (PCD_o !== 32'h0001_0000 + 32'(4 * i)) begin bad++;
        $display("FAIL drain%0d got=%h exp=%h", i, PCD_o, 32'h0001_0000 + 32'(4 * i)); end
      drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    end
    total++; if (count_o !== 3'd0 || valid_d_o !== 1'b0) begin bad++;
      $display("FAIL drained got=%0d/%b exp=0/0", count_o, valid_d_o); end
    drive_cycle(1'b0, 32'd0, 1'b1, 32'hA5A5_0001, 1'b0);
    total++; if (PCD_o !== 32'h0001_0010 || InstrD_o !== 32'hA5A5_0001) begin bad++;
      $display("FAIL resume got=%h/%h exp=00010010/a5a50001", PCD_o, InstrD_o); end
  endtask

  task automatic test_redirect();
    do_reset();
    repeat (3) drive_cycle(1'b0, 32'd0, 1'b1, $urandom, 1'b1);
    total++; if (count_o !== 3'd3) begin bad++; $display("FAIL redir_pre_count got=%0d exp=3", count_o); end
    redirect_i = 1'b1;
    #1;
    total++; if (imem_req_o !== 1'b0) begin bad++; $display("FAIL redir_req got=%b exp=0", imem_req_o); end
    drive_cycle(1'b1, 32'h0001_0203, 1'b1, 32'hDEAD_BEEF, 1'b0);
    total++; if (count_o !== 3'd0 || valid_d_o !== 1'b0 || InstrD_o !== NOP) begin bad++;
      $display("FAIL redir_flush got=%0d/%b/%h exp=0/0/00000013", count_o, valid_d_o, InstrD_o); end
    total++; if (imem_addr_o !== 32'h0001_0200) begin bad++;
      $display("FAIL redir_addr got=%h exp=00010200", imem_addr_o); end
    drive_cycle(1'b0, 32'd0, 1'b1, 32'h1234_5678, 1'b0);
    total++; if (PCD_o !== 32'h0001_0200 || InstrD_o !== 32'h1234_5678) begin bad++;
      $display("FAIL redir_first got=%h/%h exp=00010200/12345678", PCD_o, InstrD_o); end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    drive_cycle(1'b1, 32'hFFFF_FFF9, 1'b0, 32'd0, 1'b1);
    total++; if (imem_addr_o !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_start got=%h exp=fffffff8", imem_addr_o); end
    repeat (2) drive_cycle(1'b0, 32'd0, 1'b1, $urandom, 1'b1);
    total++; if (imem_addr_o !== 32'd0 || count_o !== 3'd2) begin bad++;
      $display("FAIL wrap_addr got=%h/%0d exp=00000000/2", imem_addr_o, count_o); end
    drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    total++; if (PCD_o !== 32'hFFFF_FFFC || PCPlus4D_o !== 32'd0) begin bad++;
      $display("FAIL wrap_plus4 got=%h/%h exp=fffffffc/00000000", PCD_o, PCPlus4D_o); end
  endtask

  task automatic test_ack_withheld();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (imem_req_o !== 1'b1 || imem_addr_o !== PC_START) begin bad++;
        $display("FAIL wait%0d got=%b/%h exp=1/%h", i, imem_req_o, imem_addr_o, PC_START); end
      drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    end
    total++; if (count_o !== 3'd0 || imem_addr_o !== PC_START) begin bad++;
      $display("FAIL wait_hold got=%0d/%h exp=0/%h", count_o, imem_addr_o, PC_START); end
    drive_cycle(1'b0, 32'd0, 1'b1, 32'h0BAD_F00D, 1'b1);
    total++; if (count_o !== 3'd1 || imem_addr_o !== 32'h0001_0004 || PCD_o !== PC_START) begin bad++;
      $display("FAIL wait_push got=%0d/%h/%h exp=1/00010004/%h", count_o, imem_addr_o, PCD_o, PC_START); end
  endtask

  task automatic test_push_pop();
    do_reset();
    repeat (2) drive_cycle(1'b0, 32'd0, 1'b1, $urandom, 1'b1);
    total++; if (PCD_o !== 32'h0001_0000) begin bad++; $display("FAIL pp_head got=%h exp=00010000", PCD_o); end
    drive_cycle(1'b0, 32'd0, 1'b1, 32'h7777_0008, 1'b0);
    total++; if (count_o !== 3'd2 || PCD_o !== 32'h0001_0004 || imem_addr_o !== 32'h0001_000C) begin bad++;
      $display("FAIL pp_same got=%0d/%h/%h exp=2/00010004/0001000c", count_o, PCD_o, imem_addr_o); end
    drive_cycle(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    total++; if (PCD_o !== 32'h0001_0008 || InstrD_o !== 32'h7777_0008) begin bad++;
      $display("FAIL pp_pushed got=%h/%h exp=00010008/77770008", PCD_o, InstrD_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    repeat (2) drive_cycle(1'b0, 32'd0, 1'b1, $urandom, 1'b1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    total++; if (count_o !== 3'd0 || valid_d_o !== 1'b0 || imem_addr_o !== PC_START) begin bad++;
      $display("FAIL async_reset got=%0d/%b/%h exp=0/0/%h", count_o, valid_d_o, imem_addr_o, PC_START); end
    total++; if (imem_req_o !== 1'b0 || InstrD_o !== NOP) begin bad++;
      $display("FAIL async_reset_out got=%b/%h exp=0/%h", imem_req_o, InstrD_o, NOP); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_random();
    logic        red, ack, stall;
    logic [31:0] rpc, rdata;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      red   = ($urandom_range(0, 15) == 0);
      ack   = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 2) == 0);
      rdata = $urandom;
      rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      redirect_i = red;
      #1;
      total++; if (imem_req_o !== ((mq_pc.size() < DEPTH) && !red) || imem_addr_o !== m_pcf) begin bad++;
        $display("FAIL rand_fetch n=%0d got=%b/%h exp=%b/%h", n, imem_req_o, imem_addr_o,
                 (mq_pc.size() < DEPTH) && !red, m_pcf); end
      total++; if (count_o !== 3'(mq_pc.size())) begin bad++;
        $display("FAIL rand_count n=%0d got=%0d exp=%0d", n, count_o, mq_pc.size()); end
      if (mq_pc.size() > 0) begin
        total++; if (valid_d_o !== 1'b1 || PCD_o !== mq_pc[0] || InstrD_o !== mq_instr[0] ||
                     PCPlus4D_o !== mq_pc[0] + 32'd4) begin bad++;
          $display("FAIL rand_head n=%0d got=%b/%h/%h exp=1/%h/%h", n, valid_d_o, PCD_o, InstrD_o,
                   mq_pc[0], mq_instr[0]); end
      end else begin
        total++; if (valid_d_o !== 1'b0 || PCD_o !== 32'd0 || InstrD_o !== NOP || PCPlus4D_o !== 32'd0) begin bad++;
          $display("FAIL rand_empty n=%0d got=%b/%h/%h", n, valid_d_o, PCD_o, InstrD_o); end
      end
      drive_cycle(red, rpc, ack, rdata, stall);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_full_stall();
    test_redirect();
    test_pc_wrap();
    test_ack_withheld();
    test_push_pop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
